pc_unit: RTL and testbench

Parametrised program-counter unit for the MIPS core; successor to the plain PC register.
- Holds the fetch address and computes PC+4.
- Applies stall, branch/jump/call/return redirects and exception vectoring with a fixed priority.
- Keeps a small circular return-address stack (RAS) so returns resolve without waiting on the register file.
- Sits between next-PC select logic in decode/execute and instruction memory.

---
 rtl/pc_pkg.sv | 17 +
 rtl/pc_ras.sv | 56 +++++
 rtl/pc_unit.sv | 124 ++++++++++++
 tb/tb_pc_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit.
//   - redirect_kind encodings driven by decode/execute
//   - default reset and exception vectors
//   - sequential fetch increment
package pc_pkg;

    localparam logic [1:0] KIND_BRANCH = 2'd0;
    localparam logic [1:0] KIND_JUMP   = 2'd1;
    localparam logic [1:0] KIND_CALL   = 2'd2;
    localparam logic [1:0] KIND_RET    = 2'd3;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_0080;

    localparam int PC_INCR = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack.
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-low reset
//   push, pop         at most one asserted per cycle
//   push_data         address written at entry[sp] on push
//   top               entry[sp-1], the most recent return address
//   count             number of valid entries, saturates at RAS_DEPTH
// Pushing while full overwrites the oldest entry silently.
module pc_ras
    import pc_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [ADDR_W-1:0]            push_data,
    output logic [ADDR_W-1:0]            top,
    output logic [$clog2(RAS_DEPTH):0]   count
);

    localparam int SP_W  = $clog2(RAS_DEPTH);
    localparam int CNT_W = SP_W + 1;

    logic [ADDR_W-1:0] entries [RAS_DEPTH];
    logic [SP_W-1:0]   sp;
    logic [SP_W-1:0]   sp_dec;

    assign sp_dec = sp - SP_W'(1);
    assign top    = entries[sp_dec];

    // Storage carries no reset; only the pointer and count define validity.
    always_ff @(posedge clock) begin
        if (push) begin
            entries[sp] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sp    <= '0;
            count <= '0;
        end else if (push) begin
            sp <= sp + SP_W'(1);
            if (count != CNT_W'(RAS_DEPTH)) begin
                count <= count + CNT_W'(1);
            end
        end else if (pop) begin
            sp    <= sp_dec;
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: fetch address register, PC+4, prioritised
// redirects (exception > redirect > stall > sequential) and a return
// address stack so returns resolve without the register file.
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   stall               hold pc (overridden by redirect and exception)
//   redirect_valid      redirect request; redirect_kind selects BRANCH/JUMP/CALL/RET
//   redirect_target     target for BRANCH/JUMP/CALL, fallback for RET on empty RAS
//   exc_valid           exception request, vectors to EXC_VECTOR and captures epc
//   pc, pc_plus4        current fetch address and its sequential successor
//   epc                 pc at the most recent exception
//   ras_count           valid RAS entries
//   ras_miss            one-cycle pulse after a RET found the RAS empty
//   misalign            one-cycle pulse after a misaligned redirect was trapped
// Build option: define PC_MISALIGN_TRAP_EN to turn redirects with a target
// whose low two bits are non-zero into exceptions; otherwise targets are
// used unchanged and misalign is constant 0.
module pc_unit
    import pc_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter int                RAS_DEPTH    = 8,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR),
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(DEFAULT_EXC_VECTOR)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         redirect_valid,
    input  logic [1:0]                   redirect_kind,
    input  logic [ADDR_W-1:0]            redirect_target,
    input  logic                         exc_valid,
    output logic [ADDR_W-1:0]            pc,
    output logic [ADDR_W-1:0]            pc_plus4,
    output logic [ADDR_W-1:0]            epc,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_miss,
    output logic                         misalign
);

    logic [ADDR_W-1:0] ras_top;
    logic [ADDR_W-1:0] sel_target;
    logic [ADDR_W-1:0] pc_next;
    logic              is_ret;
    logic              ret_hit;
    logic              trap;
    logic              take_exc;
    logic              push;
    logic              pop;
    logic              miss_next;

    assign pc_plus4 = pc + ADDR_W'(PC_INCR);

    assign is_ret     = redirect_valid && (redirect_kind == KIND_RET);
    assign ret_hit    = is_ret && (ras_count != '0);
    assign sel_target = ret_hit ? ras_top : redirect_target;

`ifdef PC_MISALIGN_TRAP_EN
    // The check looks at the final target, so a RAS-supplied return
    // address is covered as well as the explicit one.
    assign trap = redirect_valid && (sel_target[1:0] != 2'b00);
`else
    assign trap = 1'b0;
`endif

    assign take_exc = exc_valid || trap;

    // An external exception cancels every side effect of a concurrent
    // redirect; a misalign trap still lets a RET pop but blocks a CALL push.
    assign push      = !exc_valid && redirect_valid && (redirect_kind == KIND_CALL) && !trap;
    assign pop       = !exc_valid && ret_hit;
    assign miss_next = !exc_valid && is_ret && (ras_count == '0);

    always_comb begin
        pc_next = pc_plus4;
        if (take_exc) begin
            pc_next = EXC_VECTOR;
        end else if (redirect_valid) begin
            pc_next = sel_target;
        end else if (stall) begin
            pc_next = pc;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc       <= RESET_VECTOR;
            epc      <= '0;
            ras_miss <= 1'b0;
        end else begin
            pc       <= pc_next;
            ras_miss <= miss_next;
            if (take_exc) begin
                epc <= pc;
            end
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            misalign <= 1'b0;
        end else begin
            misalign <= !exc_valid && trap;
        end
    end
`else
    assign misalign = 1'b0;
`endif

    pc_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_plus4),
        .top       (ras_top),
        .count     (ras_count)
    );

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit (ADDR_W=32, RAS_DEPTH=8).
module tb_pc_unit;

    import pc_pkg::*;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [1:0]  redirect_kind;
    logic [31:0] redirect_target;
    logic        exc_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] epc;
    logic [3:0]  ras_count;
    logic        ras_miss;
    logic        misalign;

    int errors = 0;
    int checks = 0;

    pc_unit #(
        .ADDR_W    (32),
        .RAS_DEPTH (8)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_kind   (redirect_kind),
        .redirect_target (redirect_target),
        .exc_valid       (exc_valid),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .epc             (epc),
        .ras_count       (ras_count),
        .ras_miss        (ras_miss),
        .misalign        (misalign)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        redirect_valid  = 1'b0;
        redirect_kind   = KIND_BRANCH;
        redirect_target = 32'h0;
        exc_valid       = 1'b0;
        stall           = 1'b0;
    endtask

    task automatic redirect(input logic [1:0] kind, input logic [31:0] target);
        redirect_valid  = 1'b1;
        redirect_kind   = kind;
        redirect_target = target;
    endtask

    logic [31:0] pushed [9];

    initial begin
        reset = 1'b0;
        idle();
        #3;
        check("reset_pc", pc, 32'h0);
        check("reset_epc", epc, 32'h0);
        check("reset_count", 32'(ras_count), 32'h0);
        check("reset_miss", 32'(ras_miss), 32'h0);
        check("reset_misalign", 32'(misalign), 32'h0);
        #9;
        reset = 1'b1;

        // Sequential fetch
        step(); check("seq_4", pc, 32'h4);
        step(); check("seq_8", pc, 32'h8);
        check("plus4_8", pc_plus4, 32'hC);
        step(); check("seq_12", pc, 32'hC);

        // Asynchronous reset without a clock edge
        #1;
        reset = 1'b0;
        #1;
        check("async_reset_pc", pc, 32'h0);
        reset = 1'b1;

        // Reach 0x10, then stall for three cycles
        repeat (4) step();
        check("pre_stall", pc, 32'h10);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); check("stall_hold", pc, 32'h10);
        end
        redirect(KIND_JUMP, 32'h200);
        step(); check("stall_jump", pc, 32'h200);
        idle();

        // CALL then RET with a hit
        redirect(KIND_JUMP, 32'h20);
        step(); check("jump_20", pc, 32'h20);
        redirect(KIND_CALL, 32'h400);
        step(); check("call_pc", pc, 32'h400);
        check("call_count", 32'(ras_count), 32'h1);
        redirect(KIND_RET, 32'h0);
        step(); check("ret_pc", pc, 32'h24);
        check("ret_count", 32'(ras_count), 32'h0);
        check("ret_nomiss", 32'(ras_miss), 32'h0);

        // Nine nested calls overflow an eight-deep RAS
        for (int i = 0; i < 9; i++) begin
            pushed[i] = pc + 32'h4;
            redirect(KIND_CALL, 32'h1000 + 32'(i) * 32'h100);
            step();
            check("ncall_pc", pc, 32'h1000 + 32'(i) * 32'h100);
            check("ncall_count", 32'(ras_count), (i < 8) ? 32'(i + 1) : 32'h8);
        end
        for (int j = 0; j < 8; j++) begin
            redirect(KIND_RET, 32'h3000);
            step();
            check("nret_pc", pc, pushed[8 - j]);
            check("nret_count", 32'(ras_count), 32'(7 - j));
        end
        redirect(KIND_RET, 32'h3000);
        step();
        check("miss_pc", pc, 32'h3000);
        check("miss_pulse", 32'(ras_miss), 32'h1);
        check("miss_count", 32'(ras_count), 32'h0);
        idle();
        step();
        check("miss_clear", 32'(ras_miss), 32'h0);
        check("after_miss_pc", pc, 32'h3004);

        // Exception beats a concurrent CALL
        redirect(KIND_JUMP, 32'h30);
        step(); check("jump_30", pc, 32'h30);
        redirect(KIND_CALL, 32'h500);
        exc_valid = 1'b1;
        step();
        check("exc_pc", pc, 32'h80);
        check("exc_epc", epc, 32'h30);
        check("exc_count", 32'(ras_count), 32'h0);
        idle();
        step(); check("post_exc_pc", pc, 32'h84);

        // Misaligned jump
        redirect(KIND_JUMP, 32'h40);
        step(); check("jump_40", pc, 32'h40);
        redirect(KIND_JUMP, 32'h102);
        step();
`ifdef PC_MISALIGN_TRAP_EN
        check("mis_pc", pc, 32'h80);
        check("mis_epc", epc, 32'h40);
        check("mis_pulse", 32'(misalign), 32'h1);
`else
        check("mis_pc", pc, 32'h102);
        check("mis_epc", epc, 32'h30);
        check("mis_pulse", 32'(misalign), 32'h0);
`endif
        idle();
        step(); check("mis_clear", 32'(misalign), 32'h0);

        // Wrap at the top of the address space
        redirect(KIND_BRANCH, 32'hFFFF_FFFC);
        step(); check("wrap_top", pc, 32'hFFFF_FFFC);
        check("wrap_plus4", pc_plus4, 32'h0);
        idle();
        step(); check("wrap_zero", pc, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1);
    end

endmodule
